// File: rtl/core_pkg.sv
// Shared types and constants for the fetch stage of the five-stage core.
package core_pkg;

    localparam int unsigned CORE_XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RESET_WAIT,
        RUN,
        DRAIN
    } fetch_state_t;

    // IF/DE pipeline register payload as seen by decode.
    typedef struct packed {
        logic [31:0]           instr;
        logic [CORE_XLEN-1:0]  pc;
        logic [CORE_XLEN-1:0]  pc_plus4;
        logic                  valid;
    } ifde_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a synchronous clear and an occupancy count.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (count == '0);
    assign push_ok  = push && (count != CW'(DEPTH));
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array: data only, no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; clear discards everything in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited in-order imem requests,
// response queue and the IF/DE pipeline register.
module fetch_unit import core_pkg::*; #(
    parameter int unsigned      XLEN       = CORE_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC   = '0,
    parameter int unsigned      FIFO_DEPTH = 2,
    parameter logic [31:0]      NOP        = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_stall,
    input  logic            de_stall,
    input  logic            de_flush,
    input  logic            ex_pc_src,
    input  logic [XLEN-1:0] ex_pc_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            de_valid,
    output logic [31:0]     de_instr,
    output logic [XLEN-1:0] de_pc,
    output logic [XLEN-1:0] de_pc_plus4,
    output logic            fetch_busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = 32 + XLEN;

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [CW-1:0]   outstanding, outstanding_next;
    logic [CW-1:0]   discard_cnt, discard_next;

    // Shadow queue holding the PC of every request still in flight.
    logic [XLEN-1:0] shadow [FIFO_DEPTH];
    logic [PW-1:0]   sh_rd, sh_wr;

    logic            fifo_push, fifo_pop, fifo_clear, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [EW-1:0]   fifo_rd_data;
    logic [CW:0]     used;
    logic            has_credit, rsp_take, req_fire;

    assign imem_req_addr = pc;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .push_data ({imem_rsp_data, shadow[sh_rd]}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Next-state, request issue and queue control.
    always_comb begin
        used             = {1'b0, fifo_count} + {1'b0, outstanding};
        has_credit       = used < (CW + 1)'(FIFO_DEPTH);
        rsp_take         = imem_rsp_valid && (outstanding != '0);
        imem_req_valid   = (state != RESET_WAIT) && !if_stall && has_credit && !ex_pc_src;
        req_fire         = imem_req_valid && imem_req_ready;
        state_next       = state;
        pc_next          = pc;
        discard_next     = discard_cnt;
        outstanding_next = outstanding + CW'(req_fire) - CW'(rsp_take);
        fifo_clear       = ex_pc_src;
        fifo_push        = rsp_take && (discard_cnt == '0) && !ex_pc_src;
        fifo_pop         = !de_flush && !ex_pc_src && !de_stall && !fifo_empty;
        fetch_busy       = (state == DRAIN) || (fifo_empty && (outstanding != '0));

        if (ex_pc_src) begin
            // Everything still in flight belongs to the old path; the response
            // landing this cycle is already consumed, so it is not counted.
            pc_next      = ex_pc_target & {{(XLEN-2){1'b1}}, 2'b00};
            discard_next = outstanding - CW'(rsp_take);
            state_next   = (discard_next != '0) ? DRAIN : RUN;
        end else begin
            if (req_fire) begin
                pc_next = pc + XLEN'(4);
            end
            if (rsp_take && (discard_cnt != '0)) begin
                discard_next = discard_cnt - CW'(1);
            end
            case (state)
                RESET_WAIT: state_next = RUN;
                DRAIN:      if (discard_next == '0) state_next = RUN;
                default:    state_next = state;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // PC and in-flight/discard counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
            sh_rd       <= '0;
            sh_wr       <= '0;
        end else begin
            pc          <= pc_next;
            outstanding <= outstanding_next;
            discard_cnt <= discard_next;
            if (req_fire) begin
                sh_wr <= sh_wr + PW'(1);
            end
            if (rsp_take) begin
                sh_rd <= sh_rd + PW'(1);
            end
        end
    end

    // Shadow PC storage written on each accepted request.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            shadow[sh_wr] <= pc;
        end
    end

    // IF/DE register: flush/redirect bubble, then stall hold, then pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_valid    <= 1'b0;
            de_instr    <= NOP;
            de_pc       <= '0;
            de_pc_plus4 <= '0;
        end else if (de_flush || ex_pc_src) begin
            de_valid <= 1'b0;
            de_instr <= NOP;
        end else if (!de_stall) begin
            if (!fifo_empty) begin
                de_valid    <= 1'b1;
                de_instr    <= fifo_rd_data[EW-1:XLEN];
                de_pc       <= fifo_rd_data[XLEN-1:0];
                de_pc_plus4 <= fifo_rd_data[XLEN-1:0] + XLEN'(4);
            end else begin
                de_valid <= 1'b0;
                de_instr <= NOP;
            end
        end
    end

endmodule
